// File: rtl/logic_shift_router.sv
// Operand registers and bit-serial routing for the 8-bit logic processor.
// Optional ROUTE_LATCH_EN freezes the route select for a whole operation.
module logic_shift_router #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic             Execute,
  input  logic [WIDTH-1:0] Din,
  input  logic [1:0]       R,
  output logic             A_Ser,
  output logic             B_Ser,
  input  logic             A_Ret,
  input  logic             B_Ret,
  input  logic             F_A_B,
  output logic [WIDTH-1:0] A_Val,
  output logic [WIDTH-1:0] B_Val,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    r_sel;
  logic          new_a;
  logic          new_b;
  logic          start;

  assign start = (state == IDLE) && !LoadA && !LoadB && Execute;

`ifdef ROUTE_LATCH_EN
  logic [1:0] r_lat;

  always_ff @(posedge Clk) begin
    if (Reset)
      r_lat <= 2'b00;
    else if (start)
      r_lat <= R;
  end

  assign r_sel = r_lat;
`else
  assign r_sel = R;
`endif

  always_comb begin
    new_a = A_Ret;
    new_b = B_Ret;
    unique case (1'b1)
      (r_sel == 2'b00): begin
        new_a = A_Ret;
        new_b = B_Ret;
      end
      (r_sel == 2'b01): begin
        new_a = F_A_B;
        new_b = B_Ret;
      end
      (r_sel == 2'b10): begin
        new_a = A_Ret;
        new_b = F_A_B;
      end
      default: begin
        new_a = B_Ret;
        new_b = A_Ret;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      A_Val <= '0;
      B_Val <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (LoadA)
            A_Val <= Din;
          if (LoadB)
            B_Val <= Din;
          if (start) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          A_Val <= {new_a, A_Val[WIDTH-1:1]};
          B_Val <= {new_b, B_Val[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (cnt == LAST)
            state <= HOLD;
        end
        HOLD: begin
          if (!Execute)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign A_Ser = A_Val[0];
  assign B_Ser = B_Val[0];
  assign Busy  = (state == SHIFT);
  assign Done  = (state == HOLD);

endmodule
